// File: rtl/rf_fwd_even.sv
// Operand fetch stage: 128x128 register file with even/odd writeback ports and
// forwarding from both pipes' staging registers, one holding stage and one output stage.
module rf_fwd_even (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [0:10]       in_op,
  input  logic [2:0]        in_format,
  input  logic [1:0]        in_unit,
  input  logic [0:6]        in_rt_addr,
  input  logic [0:6]        in_ra_addr,
  input  logic [0:6]        in_rb_addr,
  input  logic [0:6]        in_rc_addr,
  input  logic              in_ra_use,
  input  logic              in_rb_use,
  input  logic              in_rc_use,
  input  logic [0:17]       in_imm,
  input  logic              in_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  input  logic [0:127]      even_wb_data,
  input  logic [0:127]      odd_wb_data,
  input  logic [0:6]        even_wb_addr,
  input  logic [0:6]        odd_wb_addr,
  input  logic              even_wb_write,
  input  logic              odd_wb_write,
  input  logic [6:0][0:127] even_fw_data,
  input  logic [6:0][0:127] odd_fw_data,
  input  logic [6:0][0:6]   even_fw_addr,
  input  logic [6:0][0:6]   odd_fw_addr,
  input  logic [6:0]        even_fw_write,
  input  logic [6:0]        odd_fw_write,
  output logic [0:10]       op,
  output logic [2:0]        format,
  output logic [1:0]        unit,
  output logic [0:6]        rt_addr,
  output logic [0:127]      ra,
  output logic [0:127]      rb,
  output logic [0:127]      rc,
  output logic [0:17]       imm,
  output logic              reg_write,
  output logic              out_valid
);

  localparam int DATA_W  = 128;
  localparam int STAGES  = 7;
  localparam int RF_SIZE = 128;

  logic [0:DATA_W-1] r_rf [RF_SIZE];

  logic              r_vld_p0;
  logic [0:10]       r_op_p0;
  logic [2:0]        r_format_p0;
  logic [1:0]        r_unit_p0;
  logic [0:6]        r_rt_addr_p0;
  logic [0:6]        r_ra_addr_p0;
  logic [0:6]        r_rb_addr_p0;
  logic [0:6]        r_rc_addr_p0;
  logic              r_ra_use_p0;
  logic              r_rb_use_p0;
  logic              r_rc_use_p0;
  logic [0:17]       r_imm_p0;
  logic              r_reg_write_p0;

  logic [0:DATA_W-1] w_ra_p0;
  logic [0:DATA_W-1] w_rb_p0;
  logic [0:DATA_W-1] w_rc_p0;
  logic              w_issue_p0;

  logic              r_vld_p1;
  logic [0:10]       r_op_p1;
  logic [2:0]        r_format_p1;
  logic [1:0]        r_unit_p1;
  logic [0:6]        r_rt_addr_p1;
  logic [0:DATA_W-1] r_ra_p1;
  logic [0:DATA_W-1] r_rb_p1;
  logic [0:DATA_W-1] r_rc_p1;
  logic [0:17]       r_imm_p1;
  logic              r_reg_write_p1;

  // Stages 0 and 1 have not produced results yet; they never take part in matching.
  logic w_unused;
  assign w_unused = ^{even_fw_data[1:0], odd_fw_data[1:0], even_fw_addr[1:0],
                      odd_fw_addr[1:0], even_fw_write[1:0], odd_fw_write[1:0]};

  assign in_ready = !stall;

  // Register file: odd writeback is the younger result when both hit the same entry.
  for (genvar g = 0; g < RF_SIZE; g++) begin : g_rf
    always_ff @(posedge clk) begin
      if (reset) begin
        r_rf[g] <= '0;
      end else if (odd_wb_write && (odd_wb_addr == 7'(g))) begin
        r_rf[g] <= odd_wb_data;
      end else if (even_wb_write && (even_wb_addr == 7'(g))) begin
        r_rf[g] <= even_wb_data;
      end
    end
  end

  // ---- p0: holding register ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_vld_p0 <= 1'b0;
    end else if (!stall) begin
      r_vld_p0 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && !flush) begin
      r_op_p0        <= in_op;
      r_format_p0    <= in_format;
      r_unit_p0      <= in_unit;
      r_rt_addr_p0   <= in_rt_addr;
      r_ra_addr_p0   <= in_ra_addr;
      r_rb_addr_p0   <= in_rb_addr;
      r_rc_addr_p0   <= in_rc_addr;
      r_ra_use_p0    <= in_ra_use;
      r_rb_use_p0    <= in_rb_use;
      r_rc_use_p0    <= in_rc_use;
      r_imm_p0       <= in_imm;
      r_reg_write_p0 <= in_reg_write;
    end
  end

  // Youngest matching producer wins: fw stages 2..6 (odd before even), then wb, then RF.
  function automatic logic [0:DATA_W-1] resolve(input logic [0:6] addr);
    logic [0:DATA_W-1] data;
    logic              hit;
    data = r_rf[addr];
    hit  = 1'b0;
    for (int s = 2; s < STAGES; s++) begin
      if (!hit && odd_fw_write[s] && (odd_fw_addr[s] == addr)) begin
        data = odd_fw_data[s];
        hit  = 1'b1;
      end
      if (!hit && even_fw_write[s] && (even_fw_addr[s] == addr)) begin
        data = even_fw_data[s];
        hit  = 1'b1;
      end
    end
    if (!hit && odd_wb_write && (odd_wb_addr == addr)) begin
      data = odd_wb_data;
      hit  = 1'b1;
    end
    if (!hit && even_wb_write && (even_wb_addr == addr)) begin
      data = even_wb_data;
    end
    return data;
  endfunction

  always_comb begin
    w_ra_p0 = '0;
    w_rb_p0 = '0;
    w_rc_p0 = '0;
    if (r_ra_use_p0) w_ra_p0 = resolve(r_ra_addr_p0);
    if (r_rb_use_p0) w_rb_p0 = resolve(r_rb_addr_p0);
    if (r_rc_use_p0) w_rc_p0 = resolve(r_rc_addr_p0);
  end

  assign w_issue_p0 = r_vld_p0 && !stall && !flush;

  // ---- p1: output register ----
  always_ff @(posedge clk) begin
    if (reset || !w_issue_p0) begin
      r_vld_p1       <= 1'b0;
      r_op_p1        <= '0;
      r_format_p1    <= '0;
      r_unit_p1      <= '0;
      r_rt_addr_p1   <= '0;
      r_ra_p1        <= '0;
      r_rb_p1        <= '0;
      r_rc_p1        <= '0;
      r_imm_p1       <= '0;
      r_reg_write_p1 <= 1'b0;
    end else begin
      r_vld_p1       <= 1'b1;
      r_op_p1        <= r_op_p0;
      r_format_p1    <= r_format_p0;
      r_unit_p1      <= r_unit_p0;
      r_rt_addr_p1   <= r_rt_addr_p0;
      r_ra_p1        <= w_ra_p0;
      r_rb_p1        <= w_rb_p0;
      r_rc_p1        <= w_rc_p0;
      r_imm_p1       <= r_imm_p0;
      r_reg_write_p1 <= r_reg_write_p0;
    end
  end

  assign op        = r_op_p1;
  assign format    = r_format_p1;
  assign unit      = r_unit_p1;
  assign rt_addr   = r_rt_addr_p1;
  assign ra        = r_ra_p1;
  assign rb        = r_rb_p1;
  assign rc        = r_rc_p1;
  assign imm       = r_imm_p1;
  assign reg_write = r_reg_write_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_rf_fwd_even.sv
// Directed bench for rf_fwd_even: RF read/write, forwarding priority, stall, flush, reset.
module tb_rf_fwd_even;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [0:10]       in_op;
  logic [2:0]        in_format;
  logic [1:0]        in_unit;
  logic [0:6]        in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
  logic              in_ra_use, in_rb_use, in_rc_use;
  logic [0:17]       in_imm;
  logic              in_reg_write;
  logic              stall, flush, in_ready;
  logic [0:127]      even_wb_data, odd_wb_data;
  logic [0:6]        even_wb_addr, odd_wb_addr;
  logic              even_wb_write, odd_wb_write;
  logic [6:0][0:127] even_fw_data, odd_fw_data;
  logic [6:0][0:6]   even_fw_addr, odd_fw_addr;
  logic [6:0]        even_fw_write, odd_fw_write;
  logic [0:10]       op;
  logic [2:0]        format;
  logic [1:0]        unit;
  logic [0:6]        rt_addr;
  logic [0:127]      ra, rb, rc;
  logic [0:17]       imm;
  logic              reg_write, out_valid;

  int checks = 0;
  int failures = 0;

  localparam logic [0:127] V5 = {16{8'h11}};
  localparam logic [0:127] VA = {16{8'hA1}};
  localparam logic [0:127] VB = {16{8'hB2}};
  localparam logic [0:127] VC = {16{8'hC3}};
  localparam logic [0:127] VD = {16{8'hD4}};
  localparam logic [0:127] VE = {16{8'hE5}};
  localparam logic [0:127] VF = {16{8'hF6}};
  localparam logic [0:127] VG = {16{8'h97}};
  localparam logic [0:127] VH = {16{8'h48}};
  localparam logic [0:127] VI = {16{8'h59}};
  localparam logic [0:127] VJ = {16{8'h6A}};
  localparam logic [0:127] VZ = {16{8'h7B}};

  rf_fwd_even dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_format(in_format),
    .in_unit(in_unit), .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr),
    .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr), .in_ra_use(in_ra_use),
    .in_rb_use(in_rb_use), .in_rc_use(in_rc_use), .in_imm(in_imm),
    .in_reg_write(in_reg_write), .stall(stall), .flush(flush), .in_ready(in_ready),
    .even_wb_data(even_wb_data), .odd_wb_data(odd_wb_data),
    .even_wb_addr(even_wb_addr), .odd_wb_addr(odd_wb_addr),
    .even_wb_write(even_wb_write), .odd_wb_write(odd_wb_write),
    .even_fw_data(even_fw_data), .odd_fw_data(odd_fw_data),
    .even_fw_addr(even_fw_addr), .odd_fw_addr(odd_fw_addr),
    .even_fw_write(even_fw_write), .odd_fw_write(odd_fw_write),
    .op(op), .format(format), .unit(unit), .rt_addr(rt_addr), .ra(ra), .rb(rb), .rc(rc),
    .imm(imm), .reg_write(reg_write), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_op = '0; in_format = '0; in_unit = '0;
    in_rt_addr = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
    in_ra_use = 1'b0; in_rb_use = 1'b0; in_rc_use = 1'b0; in_imm = '0; in_reg_write = 1'b0;
    flush = 1'b0;
    even_wb_data = '0; odd_wb_data = '0; even_wb_addr = '0; odd_wb_addr = '0;
    even_wb_write = 1'b0; odd_wb_write = 1'b0;
    even_fw_data = '0; odd_fw_data = '0; even_fw_addr = '0; odd_fw_addr = '0;
    even_fw_write = '0; odd_fw_write = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    stall = 1'b0;
    reset = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (ra !== '0 || rb !== '0 || rc !== '0) begin failures++; $display("FAIL reset_operands ra=%h rb=%h rc=%h exp=0", ra, rb, rc); end
    checks++; if ({op, format, unit, rt_addr, imm, reg_write} !== '0) begin failures++; $display("FAIL reset_fields op=%h imm=%h rw=%b exp=0", op, imm, reg_write); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rf_read();
    clear_inputs();
    even_wb_write = 1'b1; even_wb_addr = 7'd5; even_wb_data = V5;
    tick();
    even_wb_write = 1'b0;
    in_valid = 1'b1; in_op = 11'h123; in_format = 3'd5; in_unit = 2'd1; in_rt_addr = 7'd10;
    in_ra_addr = 7'd5; in_ra_use = 1'b1; in_rb_addr = 7'd5; in_rb_use = 1'b0;
    in_imm = 18'h2ABCD; in_reg_write = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_latency_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rf_valid got=%b exp=1", out_valid); end
    checks++; if (ra !== V5) begin failures++; $display("FAIL rf_ra got=%h exp=%h", ra, V5); end
    checks++; if (rb !== '0) begin failures++; $display("FAIL rf_rb_unused got=%h exp=0", rb); end
    checks++; if (op !== 11'h123 || format !== 3'd5 || unit !== 2'd1 || rt_addr !== 7'd10)
      begin failures++; $display("FAIL rf_fields op=%h fmt=%0d unit=%0d rt=%0d exp=123/5/1/10", op, format, unit, rt_addr); end
    checks++; if (imm !== 18'h2ABCD || reg_write !== 1'b1) begin failures++; $display("FAIL rf_imm got=%h rw=%b exp=2abcd/1", imm, reg_write); end
    tick();
    checks++; if (out_valid !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL rf_bubble_after valid=%b rw=%b exp=0/0", out_valid, reg_write); end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    odd_wb_write = 1'b1; odd_wb_addr = 7'd7; odd_wb_data = VA;
    tick();
    odd_wb_write = 1'b0;
    even_fw_addr[6] = 7'd7; even_fw_data[6] = VB; even_fw_write[6] = 1'b1;
    odd_fw_addr[4]  = 7'd7; odd_fw_data[4]  = VC; odd_fw_write[4]  = 1'b1;
    even_fw_addr[2] = 7'd7; even_fw_data[2] = VD; even_fw_write[2] = 1'b1;
    even_fw_addr[0] = 7'd7; even_fw_data[0] = VZ; even_fw_write[0] = 1'b1;
    odd_fw_addr[1]  = 7'd7; odd_fw_data[1]  = VZ; odd_fw_write[1]  = 1'b1;
    in_valid = 1'b1; in_op = 11'h055; in_rb_addr = 7'd7; in_rb_use = 1'b1;
    tick(); tick();
    checks++; if (rb !== VD) begin failures++; $display("FAIL fwd_stage2 got=%h exp=%h", rb, VD); end
    even_fw_write[2] = 1'b0;
    tick();
    checks++; if (rb !== VC) begin failures++; $display("FAIL fwd_stage4 got=%h exp=%h", rb, VC); end
    odd_fw_write[4] = 1'b0;
    tick();
    checks++; if (rb !== VB) begin failures++; $display("FAIL fwd_stage6 got=%h exp=%h", rb, VB); end
    even_fw_write[6] = 1'b0;
    tick();
    checks++; if (rb !== VA) begin failures++; $display("FAIL fwd_rf_ignore_s01 got=%h exp=%h", rb, VA); end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    clear_inputs();
    in_valid = 1'b1; in_op = 11'h2F0; in_rc_addr = 7'd9; in_rc_use = 1'b1; in_reg_write = 1'b1;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL stall_bubble cyc=%0d valid=%b rw=%b exp=0/0", i, out_valid, reg_write); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      if (i == 0) begin
        even_fw_addr[6] = 7'd9; even_fw_data[6] = VE; even_fw_write[6] = 1'b1;
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || reg_write !== 1'b1 || op !== 11'h2F0) begin failures++; $display("FAIL stall_release valid=%b rw=%b op=%h exp=1/1/2f0", out_valid, reg_write, op); end
    checks++; if (rc !== VE) begin failures++; $display("FAIL stall_rc got=%h exp=%h", rc, VE); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    in_valid = 1'b1; in_op = 11'h3AA; in_reg_write = 1'b1; in_ra_addr = 7'd5; in_ra_use = 1'b1;
    tick();
    flush = 1'b1; stall = 1'b1; in_op = 11'h111;
    tick();
    checks++; if (out_valid !== 1'b0 || reg_write !== 1'b0) begin failures++; $display("FAIL flush_bubble valid=%b rw=%b exp=0/0", out_valid, reg_write); end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard valid=%b exp=0", out_valid); end
    in_valid = 1'b1; in_op = 11'h0F0;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || op !== 11'h0F0 || ra !== V5) begin failures++; $display("FAIL flush_next valid=%b op=%h ra=%h exp=1/0f0/%h", out_valid, op, ra, V5); end
    clear_inputs();
    tick();
  endtask

  task automatic test_wb_paths();
    clear_inputs();
    even_wb_write = 1'b1; even_wb_addr = 7'd3; even_wb_data = VF;
    odd_wb_write  = 1'b1; odd_wb_addr  = 7'd3; odd_wb_data  = VG;
    tick();
    clear_inputs();
    in_valid = 1'b1; in_ra_addr = 7'd3; in_ra_use = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (ra !== VG) begin failures++; $display("FAIL wb_same_addr got=%h exp=%h", ra, VG); end
    in_valid = 1'b1; in_ra_addr = 7'd11; in_ra_use = 1'b1; in_rb_addr = 7'd0; in_rb_use = 1'b1;
    tick();
    in_valid = 1'b0;
    even_wb_write = 1'b1; even_wb_addr = 7'd11; even_wb_data = VI;
    odd_wb_write  = 1'b1; odd_wb_addr  = 7'd11; odd_wb_data  = VH;
    tick();
    checks++; if (ra !== VH || rb !== '0) begin failures++; $display("FAIL wb_forward ra=%h rb=%h exp=%h/0", ra, rb, VH); end
    clear_inputs();
    even_wb_write = 1'b1; even_wb_addr = 7'd0; even_wb_data = VJ;
    tick();
    clear_inputs();
    in_valid = 1'b1; in_rb_addr = 7'd0; in_rb_use = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (rb !== VJ) begin failures++; $display("FAIL wb_reg0 got=%h exp=%h", rb, VJ); end
  endtask

  task automatic test_unused_and_reset();
    clear_inputs();
    even_fw_addr[3] = 7'd4; even_fw_data[3] = VJ; even_fw_write[3] = 1'b1;
    in_valid = 1'b1; in_ra_addr = 7'd4; in_ra_use = 1'b0; in_rb_addr = 7'd4; in_rb_use = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (ra !== '0 || rb !== VJ) begin failures++; $display("FAIL unused_zero ra=%h rb=%h exp=0/%h", ra, rb, VJ); end
    clear_inputs();
    in_valid = 1'b1; in_op = 11'h7FF; in_rc_addr = 7'd5; in_rc_use = 1'b1; in_reg_write = 1'b1; in_imm = 18'h3FFFF;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++; if ({op, format, unit, rt_addr, imm, reg_write, out_valid} !== '0 || ra !== '0 || rb !== '0 || rc !== '0)
      begin failures++; $display("FAIL midreset_outputs op=%h imm=%h rc=%h v=%b exp=0", op, imm, rc, out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=0", in_ready); end
    reset = 1'b0; stall = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_hold_invalid got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_ra_addr = 7'd5; in_ra_use = 1'b1; in_rb_addr = 7'd3; in_rb_use = 1'b1;
    in_rc_addr = 7'd0; in_rc_use = 1'b1; in_imm = '0; in_op = 11'h001;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || ra !== '0 || rb !== '0 || rc !== '0) begin failures++; $display("FAIL midreset_rf_cleared v=%b ra=%h rb=%h rc=%h exp=1/0/0/0", out_valid, ra, rb, rc); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    clear_inputs();
    test_reset();
    test_rf_read();
    test_fwd_priority();
    test_stall();
    test_flush();
    test_wb_paths();
    test_unused_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
